// File: rtl/cu_fsm_pcseq.sv
// Multicycle control FSM for the RV32I core: sequences fetch, execute, load
// writeback and interrupt entry, and drives next-PC select plus datapath enables.
module cu_fsm_pcseq #(
  parameter bit INTR_EN = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_func3,
  input  logic       i_br_eq,
  input  logic       i_br_lt,
  input  logic       i_br_ltu,
  input  logic       i_intr,
  input  logic       i_mie,
  output logic       o_pc_rst,
  output logic       o_pc_write,
  output logic [2:0] o_pc_sel,
  output logic       o_reg_write,
  output logic       o_mem_rden1,
  output logic       o_mem_rden2,
  output logic       o_mem_we2,
  output logic       o_csr_we,
  output logic       o_int_taken,
  output logic       o_mret_exec
);

  localparam int unsigned OPC_W = 7;
  localparam int unsigned F3_W  = 3;
  localparam int unsigned SEL_W = 3;

  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [SEL_W-1:0] SEL_PC4    = 3'b000;
  localparam logic [SEL_W-1:0] SEL_JALR   = 3'b001;
  localparam logic [SEL_W-1:0] SEL_BRANCH = 3'b010;
  localparam logic [SEL_W-1:0] SEL_JAL    = 3'b011;
  localparam logic [SEL_W-1:0] SEL_MTVEC  = 3'b100;
  localparam logic [SEL_W-1:0] SEL_MEPC   = 3'b101;

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_WB    = 3'd3,
    S_INTR  = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_intr_pend;
  logic   w_br_taken;

  assign w_intr_pend = INTR_EN & i_intr & i_mie;

  // State register; reset wins even mid-instruction.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Branch condition from func3; reserved encodings are never taken.
  always_comb begin
    w_br_taken = 1'b0;
    case (i_func3)
      F3_W'(3'b000): w_br_taken = i_br_eq;
      F3_W'(3'b001): w_br_taken = ~i_br_eq;
      F3_W'(3'b100): w_br_taken = i_br_lt;
      F3_W'(3'b101): w_br_taken = ~i_br_lt;
      F3_W'(3'b110): w_br_taken = i_br_ltu;
      F3_W'(3'b111): w_br_taken = ~i_br_ltu;
      default:       w_br_taken = 1'b0;
    endcase
  end

  // Next state and Mealy outputs.
  always_comb begin
    w_state_nxt = r_state;
    o_pc_rst    = 1'b0;
    o_pc_write  = 1'b0;
    o_pc_sel    = SEL_PC4;
    o_reg_write = 1'b0;
    o_mem_rden1 = 1'b0;
    o_mem_rden2 = 1'b0;
    o_mem_we2   = 1'b0;
    o_csr_we    = 1'b0;
    o_int_taken = 1'b0;
    o_mret_exec = 1'b0;

    case (r_state)
      S_INIT: begin
        o_pc_rst    = 1'b1;
        w_state_nxt = S_FETCH;
      end

      S_FETCH: begin
        o_mem_rden1 = 1'b1;
        w_state_nxt = S_EXEC;
      end

      S_EXEC: begin
        w_state_nxt = w_intr_pend ? S_INTR : S_FETCH;
        o_pc_write  = 1'b1;
        case (i_opcode)
          OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: begin
            o_reg_write = 1'b1;
          end
          OPC_LOAD: begin
            // Interrupt is deferred to WB so the load completes first.
            o_pc_write  = 1'b0;
            o_mem_rden2 = 1'b1;
            w_state_nxt = S_WB;
          end
          OPC_STORE: begin
            o_mem_we2 = 1'b1;
          end
          OPC_BRANCH: begin
            o_pc_sel = w_br_taken ? SEL_BRANCH : SEL_PC4;
          end
          OPC_JAL: begin
            o_reg_write = 1'b1;
            o_pc_sel    = SEL_JAL;
          end
          OPC_JALR: begin
            o_reg_write = 1'b1;
            o_pc_sel    = SEL_JALR;
          end
          OPC_SYSTEM: begin
            if (i_func3 == F3_W'(3'b000)) begin
              o_mret_exec = 1'b1;
              o_pc_sel    = SEL_MEPC;
            end else begin
              o_reg_write = 1'b1;
              o_csr_we    = 1'b1;
            end
          end
          default: begin
          end
        endcase
      end

      S_WB: begin
        o_reg_write = 1'b1;
        o_pc_write  = 1'b1;
        w_state_nxt = w_intr_pend ? S_INTR : S_FETCH;
      end

      S_INTR: begin
        o_int_taken = 1'b1;
        o_pc_write  = 1'b1;
        o_pc_sel    = SEL_MTVEC;
        w_state_nxt = S_FETCH;
      end

      default: begin
        w_state_nxt = S_INIT;
      end
    endcase
  end

endmodule

// File: tb/tb_cu_fsm_pcseq.sv
// Directed bench for cu_fsm_pcseq: per-cycle expected outputs queued at drive
// time and compared at the falling edge; a second instance has INTR_EN = 0.
module tb_cu_fsm_pcseq;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic       br_eq, br_lt, br_ltu, intr, mie;

  logic       a_pc_rst, a_pc_write, a_reg_write, a_rden1, a_rden2, a_we2, a_csr_we, a_int, a_mret;
  logic [2:0] a_pc_sel;
  logic       b_pc_rst, b_pc_write, b_reg_write, b_rden1, b_rden2, b_we2, b_csr_we, b_int, b_mret;
  logic [2:0] b_pc_sel;

  always #5 clk = ~clk;

  cu_fsm_pcseq u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_opcode(opcode), .i_func3(func3),
    .i_br_eq(br_eq), .i_br_lt(br_lt), .i_br_ltu(br_ltu), .i_intr(intr), .i_mie(mie),
    .o_pc_rst(a_pc_rst), .o_pc_write(a_pc_write), .o_pc_sel(a_pc_sel),
    .o_reg_write(a_reg_write), .o_mem_rden1(a_rden1), .o_mem_rden2(a_rden2),
    .o_mem_we2(a_we2), .o_csr_we(a_csr_we), .o_int_taken(a_int), .o_mret_exec(a_mret)
  );

  cu_fsm_pcseq #(.INTR_EN(1'b0)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_opcode(opcode), .i_func3(func3),
    .i_br_eq(br_eq), .i_br_lt(br_lt), .i_br_ltu(br_ltu), .i_intr(intr), .i_mie(mie),
    .o_pc_rst(b_pc_rst), .o_pc_write(b_pc_write), .o_pc_sel(b_pc_sel),
    .o_reg_write(b_reg_write), .o_mem_rden1(b_rden1), .o_mem_rden2(b_rden2),
    .o_mem_we2(b_we2), .o_csr_we(b_csr_we), .o_int_taken(b_int), .o_mret_exec(b_mret)
  );

  // Output vector: {pc_rst, pc_write, pc_sel[2:0], reg_write, rden1, rden2, we2, csr_we, int_taken, mret_exec}
  logic [11:0] obs_a, obs_b;
  assign obs_a = {a_pc_rst, a_pc_write, a_pc_sel, a_reg_write, a_rden1, a_rden2, a_we2, a_csr_we, a_int, a_mret};
  assign obs_b = {b_pc_rst, b_pc_write, b_pc_sel, b_reg_write, b_rden1, b_rden2, b_we2, b_csr_we, b_int, b_mret};

  typedef struct {
    string       tag;
    logic [11:0] exp_a;
    bit          chk_b;
    logic [11:0] exp_b;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [11:0] ex(input logic prst, input logic pcw, input logic [2:0] sel,
                                     input logic rw, input logic r1, input logic r2, input logic w2,
                                     input logic csr, input logic it, input logic mr);
    return {prst, pcw, sel, rw, r1, r2, w2, csr, it, mr};
  endfunction

  localparam logic [11:0] E_INIT  = 12'b1_0_000_0_0_0_0_0_0_0;
  localparam logic [11:0] E_FETCH = 12'b0_0_000_0_1_0_0_0_0_0;
  localparam logic [11:0] E_INTR  = 12'b0_1_100_0_0_0_0_0_1_0;
  localparam logic [11:0] E_PC4   = 12'b0_1_000_0_0_0_0_0_0_0;
  localparam logic [11:0] E_ALU   = 12'b0_1_000_1_0_0_0_0_0_0;
  localparam logic [11:0] E_LOADX = 12'b0_0_000_0_0_1_0_0_0_0;
  localparam logic [11:0] E_MRET  = 12'b0_1_101_0_0_0_0_0_0_1;

  // One cycle: drive inputs, queue expectations, compare at negedge, step past posedge.
  task automatic cyc(input string tag, input logic [6:0] op, input logic [2:0] f3,
                     input logic eq, input logic lt, input logic ltu,
                     input logic it, input logic m, input logic [11:0] ea,
                     input bit cb, input logic [11:0] eb);
    exp_t e;
    opcode = op; func3 = f3; br_eq = eq; br_lt = lt; br_ltu = ltu; intr = it; mie = m;
    e.tag = tag; e.exp_a = ea; e.chk_b = cb; e.exp_b = eb;
    q.push_back(e);
    @(negedge clk);
    e = q.pop_front();
    checks++;
    assert (obs_a === e.exp_a) else begin
      failures++;
      $error("FAIL %s dut_a observed=%b expected=%b", e.tag, obs_a, e.exp_a);
    end
    if (e.chk_b) begin
      checks++;
      assert (obs_b === e.exp_b) else begin
        failures++;
        $error("FAIL %s dut_b observed=%b expected=%b", e.tag, obs_b, e.exp_b);
      end
    end
    @(posedge clk);
    #1;
  endtask

  localparam logic [6:0] NOPC = 7'b0000000;

  initial begin
    rst = 1'b1; opcode = NOPC; func3 = 3'b000;
    br_eq = 1'b0; br_lt = 1'b0; br_ltu = 1'b0; intr = 1'b0; mie = 1'b0;
    @(posedge clk); #1;

    // Reset held for two edges, then release
    cyc("rst_init1", NOPC, 3'b000, 0, 0, 0, 1, 1, E_INIT, 1, E_INIT);
    rst = 1'b0;
    cyc("rst_init2", NOPC, 3'b000, 0, 0, 0, 0, 0, E_INIT, 1, E_INIT);
    cyc("rst_fetch", NOPC, 3'b000, 0, 0, 0, 0, 0, E_FETCH, 1, E_FETCH);

    // ADDI
    cyc("addi_exec", 7'b0010011, 3'b000, 0, 0, 0, 0, 0, E_ALU, 0, '0);
    cyc("addi_fetch", NOPC, 3'b000, 0, 0, 0, 0, 0, E_FETCH, 0, '0);

    // Branches
    cyc("bne_taken", 7'b1100011, 3'b001, 0, 0, 0, 0, 0, ex(0,1,3'b010,0,0,0,0,0,0,0), 0, '0);
    cyc("f_bgeu", NOPC, 3'b000, 0, 0, 0, 0, 0, E_FETCH, 0, '0);
    cyc("bgeu_nt", 7'b1100011, 3'b111, 0, 0, 1, 0, 0, E_PC4, 0, '0);
    cyc("f_f3_010", NOPC, 3'b000, 0, 0, 0, 0, 0, E_FETCH, 0, '0);
    cyc("br_f3_010", 7'b1100011, 3'b010, 1, 1, 1, 0, 0, E_PC4, 0, '0);
    cyc("f_beq", NOPC, 3'b000, 0, 0, 0, 0, 0, E_FETCH, 0, '0);
    cyc("beq_taken", 7'b1100011, 3'b000, 1, 0, 0, 0, 0, ex(0,1,3'b010,0,0,0,0,0,0,0), 0, '0);
    cyc("f_blt", NOPC, 3'b000, 0, 0, 0, 0, 0, E_FETCH, 0, '0);
    cyc("blt_nt", 7'b1100011, 3'b100, 0, 0, 1, 0, 0, E_PC4, 0, '0);

    // Other opcodes; intr during FETCH alone is ignored
    cyc("f_store", NOPC, 3'b000, 0, 0, 0, 1, 1, E_FETCH, 0, '0);
    cyc("store", 7'b0100011, 3'b010, 0, 0, 0, 0, 1, ex(0,1,3'b000,0,0,0,1,0,0,0), 0, '0);
    cyc("f_jal", NOPC, 3'b000, 0, 0, 0, 0, 0, E_FETCH, 0, '0);
    cyc("jal", 7'b1101111, 3'b000, 0, 0, 0, 0, 0, ex(0,1,3'b011,1,0,0,0,0,0,0), 0, '0);
    cyc("f_jalr", NOPC, 3'b000, 0, 0, 0, 0, 0, E_FETCH, 0, '0);
    cyc("jalr", 7'b1100111, 3'b000, 0, 0, 0, 0, 0, ex(0,1,3'b001,1,0,0,0,0,0,0), 0, '0);
    cyc("f_csr", NOPC, 3'b000, 0, 0, 0, 0, 0, E_FETCH, 0, '0);
    cyc("csrrw", 7'b1110011, 3'b001, 0, 0, 0, 0, 0, ex(0,1,3'b000,1,0,0,0,1,0,0), 0, '0);
    cyc("f_lui", NOPC, 3'b000, 0, 0, 0, 0, 0, E_FETCH, 0, '0);
    cyc("lui", 7'b0110111, 3'b000, 0, 0, 0, 0, 0, E_ALU, 0, '0);
    cyc("f_nop", NOPC, 3'b000, 0, 0, 0, 0, 0, E_FETCH, 0, '0);
    cyc("unknown_nop", 7'b1111111, 3'b000, 0, 0, 0, 0, 0, E_PC4, 0, '0);

    // MRET with intr masked by mie = 0
    cyc("f_mret0", NOPC, 3'b000, 0, 0, 0, 1, 0, E_FETCH, 0, '0);
    cyc("mret_mie0", 7'b1110011, 3'b000, 0, 0, 0, 1, 0, E_MRET, 0, '0);
    cyc("mret_mie0_fetch", NOPC, 3'b000, 0, 0, 0, 0, 0, E_FETCH, 0, '0);

    // MRET with interrupt pending: INTR follows
    cyc("mret_mie1", 7'b1110011, 3'b000, 0, 0, 0, 1, 1, E_MRET, 0, '0);
    cyc("mret_intr", 7'b1110011, 3'b000, 0, 0, 0, 1, 1, E_INTR, 0, '0);
    cyc("mret_intr_fetch", NOPC, 3'b000, 0, 0, 0, 1, 1, E_FETCH, 0, '0);

    // Load with interrupt raised during EXEC: EXEC, WB, INTR, FETCH
    cyc("load_exec", 7'b0000011, 3'b010, 0, 0, 0, 1, 1, E_LOADX, 0, '0);
    cyc("load_wb", 7'b0000011, 3'b010, 0, 0, 0, 1, 1, E_ALU, 0, '0);
    cyc("load_intr", NOPC, 3'b000, 0, 0, 0, 1, 1, E_INTR, 0, '0);
    cyc("load_fetch", NOPC, 3'b000, 0, 0, 0, 0, 0, E_FETCH, 0, '0);

    // Reset during load EXEC
    rst = 1'b1;
    cyc("rst_mid_load", 7'b0000011, 3'b010, 0, 0, 0, 0, 0, E_LOADX, 0, '0);
    rst = 1'b0;
    cyc("rst_mid_init", 7'b0000011, 3'b010, 0, 0, 0, 1, 1, E_INIT, 1, E_INIT);
    cyc("rst_mid_fetch", NOPC, 3'b000, 0, 0, 0, 1, 1, E_FETCH, 1, E_FETCH);

    // INTR_EN = 0 instance ignores intr after MRET
    cyc("en_mret", 7'b1110011, 3'b000, 0, 0, 0, 1, 1, E_MRET, 1, E_MRET);
    cyc("en_split", NOPC, 3'b000, 0, 0, 0, 1, 1, E_INTR, 1, E_FETCH);
    cyc("en_b_exec", NOPC, 3'b000, 0, 0, 0, 1, 1, E_FETCH, 1, E_PC4);
    cyc("en_b_fetch", NOPC, 3'b000, 0, 0, 0, 1, 1, E_PC4, 1, E_FETCH);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cu_fsm_pcseq.md
Name: cu_fsm_pcseq

Overview:
- Multicycle control FSM for the RV32I core.
- Sequences instruction fetch, execute, load writeback and interrupt entry.
- Generates the 3-bit next-PC select code and the PC write strobe consumed by the PC source mux and PC register.
- Also drives register-file, memory and CSR enables.
- Sits between the decoder fields (opcode/func3), the branch comparator and the datapath.

Parameters:
- INTR_EN, 1, 1 = honour the intr input; 0 = never enter INTERRUPT.

Ports:
- clk  input  1  system clock, all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- opcode  input  7  ir[6:0] of the current instruction
- func3  input  3  ir[14:12]
- br_eq  input  1  rs1 == rs2
- br_lt  input  1  rs1 < rs2 signed
- br_ltu  input  1  rs1 < rs2 unsigned
- intr  input  1  external interrupt request, level
- mie  input  1  CSR mstatus.MIE
- pc_rst  output  1  clears PC register
- pc_write  output  1  PC register load enable
- pc_sel  output  3  next-PC code: 000 pc+4, 001 jalr, 010 branch, 011 jal, 100 mtvec, 101 mepc
- reg_write  output  1  register-file write enable
- mem_rden1  output  1  instruction memory read
- mem_rden2  output  1  data memory read
- mem_we2  output  1  data memory write
- csr_we  output  1  CSR write enable
- int_taken  output  1  interrupt entry; CSR saves PC to mepc, clears MIE
- mret_exec  output  1  MRET executing; CSR restores MIE

Behaviour:
- State register is the only storage. It updates on the rising clk edge.
- Outputs are combinational from state, opcode, func3, branch flags and intr.
- Any output not listed for a state is 0, and pc_sel defaults to 000.
- States: INIT, FETCH, EXEC, WB, INTR.
- rst = 1 at a clock edge forces INIT from any state, including mid-instruction.
- INIT: pc_rst = 1, all other outputs 0. Next state is FETCH.
- FETCH: mem_rden1 = 1. Next state is EXEC (one-cycle memory latency).
- EXEC, decoded by opcode:
  - 0110011, 0010011, 0110111, 0010111 (OP, OP-IMM, LUI, AUIPC): reg_write, pc_write, pc_sel = 000.
  - 0000011 load: mem_rden2 = 1, no pc_write. Next state is WB.
  - 0100011 store: mem_we2, pc_write, pc_sel = 000.
  - 1100011 branch: pc_write. Taken → pc_sel = 010; otherwise 000.
    - func3 000 beq: taken if br_eq.
    - 001 bne: taken if !br_eq.
    - 100 blt: taken if br_lt.
    - 101 bge: taken if !br_lt.
    - 110 bltu: taken if br_ltu.
    - 111 bgeu: taken if !br_ltu.
    - 010/011: never taken.
  - 1101111 jal: reg_write, pc_write, pc_sel = 011.
  - 1100111 jalr: reg_write, pc_write, pc_sel = 001.
  - 1110011 system, func3 = 000 (MRET): pc_write, mret_exec, pc_sel = 101.
  - 1110011 system, func3 ≠ 000 (CSR op): reg_write, csr_we, pc_write, pc_sel = 000.
  - Any other opcode: executed as NOP with pc_write, pc_sel = 000.
- WB: reg_write, pc_write, pc_sel = 000.
- Interrupt pending = INTR_EN & intr & mie, sampled combinationally in EXEC (non-load) and WB only.
- Leaving EXEC (non-load) or WB: pending → INTR; else → FETCH.
- A load never goes EXEC → INTR; the interrupt is checked in WB instead.
- INTR: int_taken, pc_write, pc_sel = 100. Next state is FETCH.
  - INTR is always one cycle.
  - intr is not re-sampled in INTR, so back-to-back INTR is impossible.
- MRET with pending interrupt in the same EXEC cycle: the MRET actions complete (PC ← mepc), then INTR follows. The saved mepc is therefore the MRET target.
- intr asserted only during FETCH or INIT is ignored unless still high at the next EXEC/WB.
- CPI: 2 for non-load, 3 for load, +1 per interrupt taken.

Test Plan:
- Reset: rst = 1 for 2 cycles in any state → INIT, pc_rst = 1, all other outputs 0. Next cycle is FETCH with mem_rden1 = 1.
- ADDI: opcode 0010011 → FETCH then EXEC with reg_write = 1, pc_write = 1, pc_sel = 000. Returns to FETCH after 2 cycles.
- Branches:
  - bne (func3 001), br_eq = 0 → pc_sel = 010.
  - bgeu (func3 111), br_ltu = 1 → pc_sel = 000.
  - func3 010 → pc_sel = 000.
  - pc_write = 1 in all cases.
- Load with interrupt: opcode 0000011 with intr = 1, mie = 1 asserted during EXEC.
  - EXEC: mem_rden2 = 1, pc_write = 0.
  - WB: reg_write = 1, pc_write = 1.
  - INTR: int_taken = 1, pc_sel = 100.
  - Then FETCH.
- MRET + interrupt masking:
  - opcode 1110011, func3 000, intr = 1, mie = 0 → EXEC: mret_exec = 1, pc_sel = 101, then FETCH.
  - Repeat with mie = 1 → INTR follows EXEC.
  - Repeat with INTR_EN = 0, intr = 1, mie = 1 → FETCH follows EXEC, int_taken never 1.
- Reset mid-load: rst = 1 during EXEC of a load → next state INIT. No reg_write or pc_write occurs at the following edge.
